// File: rtl/comp_filt_pkg.sv
// rtl/comp_filt_pkg.sv - shared types and codes for the complementary filter
package comp_filt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_OUT
  } state_t;

  localparam logic [1:0] DIR_FWD  = 2'd0;
  localparam logic [1:0] DIR_REV  = 2'd1;
  localparam logic [1:0] DIR_STOP = 2'd2;

  localparam int Q_FRAC_DEFAULT = 16;
  localparam int Q_ONE_DEFAULT  = 1 << Q_FRAC_DEFAULT;

endpackage

// File: rtl/cf_mul.sv
// rtl/cf_mul.sv - pipelined signed multiplier, result floored by >>> FRAC_W
module cf_mul #(
  parameter int DATA_W  = 32,
  parameter int FRAC_W  = 16,
  parameter int MUL_LAT = 2,
  parameter int OUT_W   = DATA_W + 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic signed [OUT_W-1:0]  p,
  output logic                     out_valid,
  output logic                     out_last
);

  logic signed [2*DATA_W-1:0] prod_full;
  logic signed [OUT_W-1:0]    pipe [MUL_LAT];
  logic [MUL_LAT-1:0]         vld;
  logic [MUL_LAT-1:0]         lst;

  assign prod_full = (2*DATA_W)'(a) * (2*DATA_W)'(b);

  // valid/last travel alongside the product so the consumer never counts cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      lst <= '0;
      for (int i = 0; i < MUL_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= OUT_W'(prod_full >>> FRAC_W);
      vld[0]  <= in_valid;
      lst[0]  <= in_valid && in_last;
      for (int i = 1; i < MUL_LAT; i++) begin
        pipe[i] <= pipe[i-1];
        vld[i]  <= vld[i-1];
        lst[i]  <= lst[i-1];
      end
    end
  end

  assign p         = pipe[MUL_LAT-1];
  assign out_valid = vld[MUL_LAT-1];
  assign out_last  = lst[MUL_LAT-1];

endmodule

// File: rtl/comp_filter_mc.sv
// rtl/comp_filter_mc.sv - multi-channel complementary filter, one shared multiplier
// Optional COMP_FILT_HYST_EN adds hysteresis to the tilt-direction output.
module comp_filter_mc
  import comp_filt_pkg::*;
#(
  parameter int NCH     = 3,
  parameter int DATA_W  = 32,
  parameter int FRAC_W  = Q_FRAC_DEFAULT,
  parameter int K_ANG   = 58982,
  parameter int K_GYR   = 2949,
  parameter int K_ACC   = 6554,
  parameter int MUL_LAT = 2,
  parameter int DIR_TH  = 327680
`ifdef COMP_FILT_HYST_EN
  , parameter int DIR_HYS = 65536
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NCH*DATA_W-1:0] acc_angle,
  input  logic [NCH*DATA_W-1:0] gyro_rate,
  output logic                  out_valid,
  output logic [NCH*DATA_W-1:0] angle_out,
  output logic [NCH*2-1:0]      dir
);

  localparam int SUM_W = DATA_W + 2;
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PH_W  = (MUL_LAT > 3) ? $clog2(MUL_LAT) : 2;

  localparam logic signed [DATA_W-1:0] KA  = DATA_W'(K_ANG);
  localparam logic signed [DATA_W-1:0] KG  = DATA_W'(K_GYR);
  localparam logic signed [DATA_W-1:0] KC  = DATA_W'(K_ACC);
  localparam logic signed [DATA_W-1:0] TH  = DATA_W'(DIR_TH);
  localparam logic signed [DATA_W-1:0] NTH = -DATA_W'(DIR_TH);
`ifdef COMP_FILT_HYST_EN
  localparam logic signed [DATA_W-1:0] TH_LO  = DATA_W'(DIR_TH - DIR_HYS);
  localparam logic signed [DATA_W-1:0] NTH_LO = -DATA_W'(DIR_TH - DIR_HYS);
`endif
  localparam logic signed [SUM_W-1:0] SAT_MAX = {3'b000, {(DATA_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = {3'b111, {(DATA_W-1){1'b0}}};

  state_t                    state;
  logic [CH_W-1:0]           ch;
  logic [PH_W-1:0]           ph;
  logic                      seeded;
  logic signed [DATA_W-1:0]  acc_q  [NCH];
  logic signed [DATA_W-1:0]  rate_q [NCH];
  logic signed [DATA_W-1:0]  ang_q  [NCH];
  logic signed [SUM_W-1:0]   sum_q;
  logic signed [SUM_W-1:0]   sum_nxt;
  logic signed [DATA_W-1:0]  mul_a;
  logic signed [DATA_W-1:0]  mul_b;
  logic signed [SUM_W-1:0]   mul_p;
  logic                      mul_v;
  logic                      mul_last;

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [SUM_W-1:0] s);
    if (s > SAT_MAX)      return DATA_W'(SAT_MAX);
    else if (s < SAT_MIN) return DATA_W'(SAT_MIN);
    else                  return DATA_W'(s);
  endfunction

  // issue order per channel: previous angle, gyro rate, accel angle
  always_comb begin
    mul_a = ang_q[ch];
    mul_b = KA;
    case (ph)
      PH_W'(0): begin mul_a = ang_q[ch];  mul_b = KA; end
      PH_W'(1): begin mul_a = rate_q[ch]; mul_b = KG; end
      default:  begin mul_a = acc_q[ch];  mul_b = KC; end
    endcase
  end

  cf_mul #(
    .DATA_W  (DATA_W),
    .FRAC_W  (FRAC_W),
    .MUL_LAT (MUL_LAT),
    .OUT_W   (SUM_W)
  ) u_mul (
    .clk       (clk),
    .rst       (rst),
    .a         (mul_a),
    .b         (mul_b),
    .in_valid  (state == ST_ISSUE),
    .in_last   (ph == PH_W'(2)),
    .p         (mul_p),
    .out_valid (mul_v),
    .out_last  (mul_last)
  );

  assign sum_nxt = sum_q + mul_p;

  // last product lands in the final drain cycle, while ch still names this channel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
      for (int i = 0; i < NCH; i++) ang_q[i] <= '0;
    end else if (mul_v) begin
      if (mul_last) begin
        ang_q[ch] <= seeded ? sat(sum_nxt) : acc_q[ch];
        sum_q     <= '0;
      end else begin
        sum_q <= sum_nxt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ch        <= '0;
      ph        <= '0;
      seeded    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      angle_out <= '0;
      dir       <= {NCH{DIR_STOP}};
      for (int i = 0; i < NCH; i++) begin
        acc_q[i]  <= '0;
        rate_q[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            for (int i = 0; i < NCH; i++) begin
              acc_q[i]  <= acc_angle[i*DATA_W +: DATA_W];
              rate_q[i] <= gyro_rate[i*DATA_W +: DATA_W];
            end
            in_ready <= 1'b0;
            ch       <= '0;
            ph       <= '0;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (ph == PH_W'(2)) begin
            ph    <= '0;
            state <= ST_DRAIN;
          end else begin
            ph <= ph + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (ph == PH_W'(MUL_LAT-1)) begin
            ph <= '0;
            if (ch == CH_W'(NCH-1)) begin
              state <= ST_OUT;
            end else begin
              ch    <= ch + 1'b1;
              state <= ST_ISSUE;
            end
          end else begin
            ph <= ph + 1'b1;
          end
        end
        default: begin
          for (int i = 0; i < NCH; i++) begin
            angle_out[i*DATA_W +: DATA_W] <= ang_q[i];
            if (ang_q[i] > TH)       dir[2*i +: 2] <= DIR_FWD;
            else if (ang_q[i] < NTH) dir[2*i +: 2] <= DIR_REV;
`ifdef COMP_FILT_HYST_EN
            else if (!((dir[2*i +: 2] == DIR_FWD && ang_q[i] >= TH_LO) ||
                       (dir[2*i +: 2] == DIR_REV && ang_q[i] <= NTH_LO)))
              dir[2*i +: 2] <= DIR_STOP;
`else
            else                     dir[2*i +: 2] <= DIR_STOP;
`endif
          end
          seeded    <= 1'b1;
          out_valid <= 1'b1;
          in_ready  <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
